// File: rtl/bist_pkg.sv
// Shared types and pure step functions for the STUMPS logic-BIST controller.
// Functions work on MAX_W-bit vectors so any LFSR/MISR width below MAX_W can share them.
package bist_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CAPT, UNLOAD, FIN} state_t;

  localparam int MAX_W = 64;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

  // Galois right-shift LFSR step; the caller zero-extends and truncates to its own width.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] l,
                                                 input logic [MAX_W-1:0] poly);
    return (l >> 1) ^ (l[0] ? poly : '0);
  endfunction

  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] m,
                                                 input logic [MAX_W-1:0] poly,
                                                 input logic [MAX_W-1:0] data,
                                                 input int               width);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    return ((m << 1) ^ (m[width-1] ? poly : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting the scan-out bits of all chains.
// STUMPS_BIST_XMASK_EN adds a per-chain mask that forces masked chains to contribute 0.
module bist_misr
  import bist_pkg::*;
#(
  parameter int             W      = 16,
  parameter int             CHAINS = 4,
  parameter logic [W-1:0]   POLY   = DEF_MISR_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [CHAINS-1:0] so_data,
`ifdef STUMPS_BIST_XMASK_EN
  input  logic [CHAINS-1:0] xmask,
`endif
  output logic [W-1:0]      signature
);

  logic [CHAINS-1:0] data;

`ifdef STUMPS_BIST_XMASK_EN
  assign data = so_data & ~xmask;
`else
  assign data = so_data;
`endif

  // Clear wins over enable so a restart never folds a stale bit into the new signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= W'(misr_step(MAX_W'(signature), MAX_W'(POLY), MAX_W'(data), W));
    end
  end

endmodule

// File: rtl/stumps_bist_ctrl.sv
// STUMPS logic-BIST controller: LFSR pattern source, shift/capture sequencer, MISR compaction.
// Optional XMASK input is compiled in with STUMPS_BIST_XMASK_EN.
module stumps_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                 CHAINS    = 4,
  parameter int                 CHAIN_LEN = 16,
  parameter int                 PATTERNS  = 256,
  parameter int                 LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = DEF_LFSR_SEED,
  parameter int                 MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0]  GOLDEN    = '0,
  localparam int                CNT_W     = $clog2(PATTERNS + 1)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic [CHAINS-1:0] SO_DATA,
`ifdef STUMPS_BIST_XMASK_EN
  input  logic [CHAINS-1:0] XMASK,
`endif
  output logic [CHAINS-1:0] SI_DATA,
  output logic              SCAN_EN,
  output logic              CAPTURE,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIGNATURE,
  output logic [CNT_W-1:0]  PAT_CNT
);

  localparam int                SH_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int                STRIDE   = LFSR_W / CHAINS;
  localparam logic [LFSR_W-1:0] SEED     = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [SH_W-1:0]   SH_LAST  = SH_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  PAT_LAST = CNT_W'(PATTERNS);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [SH_W-1:0]   shift_cnt;
  logic              first_load;
  logic              start_ok;
  logic              misr_en;

  function automatic logic [CHAINS-1:0] taps(input logic [LFSR_W-1:0] l);
    logic [CHAINS-1:0] t;
    t = '0;
    for (int i = 0; i < CHAINS; i++) t[i] = l[i*STRIDE];
    return t;
  endfunction

  assign lfsr_next = LFSR_W'(lfsr_step(MAX_W'(lfsr), MAX_W'(LFSR_POLY)));

  // A restart from FIN waits until DONE has been shown for at least one cycle.
  assign start_ok = START && ((state == IDLE) || ((state == FIN) && DONE));
  assign misr_en  = ((state == LOAD) && !first_load) || (state == UNLOAD);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lfsr       <= SEED;
      shift_cnt  <= '0;
      first_load <= 1'b0;
      SI_DATA    <= '0;
      SCAN_EN    <= 1'b0;
      CAPTURE    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      PAT_CNT    <= '0;
    end else begin
      CAPTURE <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start_ok) begin
            state      <= LOAD;
            lfsr       <= SEED;
            SI_DATA    <= taps(SEED);
            SCAN_EN    <= 1'b1;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            PAT_CNT    <= '0;
            shift_cnt  <= '0;
            first_load <= 1'b1;
          end else if ((state == FIN) && !DONE) begin
            DONE <= 1'b1;
            PASS <= (SIGNATURE == GOLDEN);
          end
        end
        LOAD: begin
          lfsr      <= lfsr_next;
          SI_DATA   <= taps(lfsr_next);
          shift_cnt <= shift_cnt + SH_W'(1);
          if (shift_cnt == SH_LAST) begin
            state      <= CAPT;
            SCAN_EN    <= 1'b0;
            CAPTURE    <= 1'b1;
            PAT_CNT    <= PAT_CNT + CNT_W'(1);
            shift_cnt  <= '0;
            first_load <= 1'b0;
          end
        end
        CAPT: begin
          SCAN_EN <= 1'b1;
          if (PAT_CNT == PAT_LAST) begin
            state   <= UNLOAD;
            SI_DATA <= '0;
          end else begin
            state <= LOAD;
          end
        end
        UNLOAD: begin
          shift_cnt <= shift_cnt + SH_W'(1);
          if (shift_cnt == SH_LAST) begin
            state     <= FIN;
            SCAN_EN   <= 1'b0;
            BUSY      <= 1'b0;
            shift_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bist_misr #(
    .W      (MISR_W),
    .CHAINS (CHAINS),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk       (CK),
    .rst       (RST),
    .clear     (start_ok),
    .enable    (misr_en),
    .so_data   (SO_DATA),
`ifdef STUMPS_BIST_XMASK_EN
    .xmask     (XMASK),
`endif
    .signature (SIGNATURE)
  );

endmodule
